// File: rtl/sequenciador_mensagem_serial_uc_pkg.sv
// Shared constants for the telemetry frame sequencer: ASCII codes and FSM encoding.
package sequenciador_mensagem_serial_uc_pkg;

    localparam logic [7:0] ASCII_ZERO        = 8'h30;
    localparam logic [7:0] ASCII_INVALIDO    = 8'h3F;
    localparam logic [7:0] SEPARADOR_PADRAO  = 8'h2C;
    localparam logic [7:0] TERMINADOR_PADRAO = 8'h23;

    // FSM state encoding (3 bits)
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCarrega = 3'd1;
    localparam logic [2:0] StEnvia   = 3'd2;
    localparam logic [2:0] StEspera  = 3'd3;
    localparam logic [2:0] StProximo = 3'd4;
    localparam logic [2:0] StFim     = 3'd5;

endpackage

// File: rtl/bcd_para_ascii.sv
// Converts one BCD digit to its ASCII character; digits above 9 map to '?'.
module bcd_para_ascii
    import sequenciador_mensagem_serial_uc_pkg::*;
(
    input  logic [3:0] digito_i,
    output logic [7:0] ascii_o
);

    // Digit to ASCII, with invalid BCD flagged only by the '?' character
    always_comb begin
        if (digito_i <= 4'd9) begin
            ascii_o = ASCII_ZERO + {4'h0, digito_i};
        end else begin
            ascii_o = ASCII_INVALIDO;
        end
    end

endmodule

// File: rtl/sequenciador_mensagem_serial_uc.sv
// Control unit that sends one telemetry frame (NUM_CAMPOS BCD fields as ASCII, separated by
// SEPARADOR and closed by TERMINADOR) through a serial TX with a partida/pronto handshake.
module sequenciador_mensagem_serial_uc
    import sequenciador_mensagem_serial_uc_pkg::*;
#(
    parameter int unsigned NUM_CAMPOS = 3,
    parameter logic [7:0]  SEPARADOR  = SEPARADOR_PADRAO,
    parameter logic [7:0]  TERMINADOR = TERMINADOR_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic [8*NUM_CAMPOS-1:0] valores,
    input  logic                    pronto_tx,
    output logic                    partida_tx,
    output logic [7:0]              dado_tx,
    output logic                    ocupado,
    output logic                    pronto
);

    localparam int unsigned        CampoW      = (NUM_CAMPOS > 1) ? $clog2(NUM_CAMPOS) : 1;
    localparam logic [CampoW-1:0]  UltimoCampo = CampoW'(NUM_CAMPOS - 1);

    logic [2:0]              estado_q, estado_d;
    logic [CampoW-1:0]       campo_q, campo_d;
    logic [1:0]              posicao_q, posicao_d;
    logic [8*NUM_CAMPOS-1:0] snapshot_q, snapshot_d;

    logic [7:0] campo_sel;
    logic [3:0] digito;
    logic [7:0] digito_ascii;
    logic [7:0] caractere;
    logic       ultimo_campo;

    assign ultimo_campo = (campo_q == UltimoCampo);

    // Next-state logic for the FSM, the field/position counters and the frame snapshot
    always_comb begin
        estado_d   = estado_q;
        campo_d    = campo_q;
        posicao_d  = posicao_q;
        snapshot_d = snapshot_q;
        case (estado_q)
            StIdle: begin
                if (iniciar) estado_d = StCarrega;
            end
            StCarrega: begin
                snapshot_d = valores;
                campo_d    = '0;
                posicao_d  = '0;
                estado_d   = StEnvia;
            end
            StEnvia: begin
                estado_d = StEspera;
            end
            StEspera: begin
                if (pronto_tx) estado_d = StProximo;
            end
            StProximo: begin
                if (posicao_q < 2'd2) begin
                    posicao_d = posicao_q + 2'd1;
                    estado_d  = StEnvia;
                end else if (!ultimo_campo) begin
                    campo_d   = campo_q + CampoW'(1);
                    posicao_d = '0;
                    estado_d  = StEnvia;
                end else begin
                    estado_d = StFim;
                end
            end
            StFim: begin
                estado_d = StIdle;
            end
            default: begin
                estado_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= StIdle;
            campo_q    <= '0;
            posicao_q  <= '0;
            snapshot_q <= '0;
        end else begin
            estado_q   <= estado_d;
            campo_q    <= campo_d;
            posicao_q  <= posicao_d;
            snapshot_q <= snapshot_d;
        end
    end

    // Select the current field byte from the snapshot
    always_comb begin
        campo_sel = snapshot_q[7:0];
        for (int k = 0; k < NUM_CAMPOS; k++) begin
            if (campo_q == CampoW'(k)) campo_sel = snapshot_q[8*k +: 8];
        end
    end

    assign digito = (posicao_q == 2'd0) ? campo_sel[7:4] : campo_sel[3:0];

    // One shared converter: only one digit is on the line at a time
    bcd_para_ascii u_bcd_para_ascii (
        .digito_i (digito),
        .ascii_o  (digito_ascii)
    );

    // Character for the current position: digit, separator or terminator
    always_comb begin
        if (posicao_q == 2'd2) begin
            caractere = ultimo_campo ? TERMINADOR : SEPARADOR;
        end else begin
            caractere = digito_ascii;
        end
    end

    assign partida_tx = (estado_q == StEnvia);
    assign ocupado    = (estado_q != StIdle);
    assign pronto     = (estado_q == StFim);
    // Counters only move on leaving PROXIMO, so the character is steady across ENVIA/ESPERA
    assign dado_tx    = ((estado_q == StIdle) || (estado_q == StCarrega)) ? 8'h00 : caractere;

endmodule
